// File: rtl/cory_vtap2.sv
// cory_vtap2: vertical 2-tap window (current + previous-row sample).
// CORY_VTAP2_BORDER_REPLICATE_EN: replicate top border instead of zero pad.
module cory_vtap2 #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_a_v,
  input  logic [N-1:0] i_a_d,
  input  logic         i_a_last_x,
  input  logic         i_a_last_y,
  output logic         o_a_r,
  output logic         o_z_v,
  output logic [N-1:0] o_z_d,
  output logic [N-1:0] o_z_up,
  output logic         o_z_up_v,
  output logic         o_z_last_x,
  output logic         o_z_last_y,
  input  logic         i_z_r
);

  localparam int D = 1 << W;

  logic [N-1:0] line_q [D];

  logic [W-1:0] col_q, col_d;
  logic         row0_q, row0_d;
  logic         v_q, v_d;
  logic [N-1:0] d_q, d_d;
  logic [N-1:0] up_q, up_d;
  logic         upv_q, upv_d;
  logic         lx_q, lx_d;
  logic         ly_q, ly_d;

  logic         acc;
  logic [N-1:0] rd;
  logic [N-1:0] border;

  assign o_a_r = ~v_q | i_z_r;
  assign acc   = i_a_v & o_a_r;
  assign rd    = line_q[col_q];

`ifdef CORY_VTAP2_BORDER_REPLICATE_EN
  assign border = i_a_d;
`else
  assign border = '0;
`endif

  always_comb begin
    col_d  = col_q;
    row0_d = row0_q;
    v_d    = v_q;
    d_d    = d_q;
    up_d   = up_q;
    upv_d  = upv_q;
    lx_d   = lx_q;
    ly_d   = ly_q;
    if (acc) begin
      v_d   = 1'b1;
      d_d   = i_a_d;
      upv_d = ~row0_q;
      up_d  = row0_q ? border : rd;
      lx_d  = i_a_last_x;
      ly_d  = i_a_last_y;
      // last_y only counts when it rides on a row end
      if (i_a_last_x) begin
        col_d  = '0;
        row0_d = i_a_last_y;
      end else begin
        col_d  = col_q + 1'b1;
      end
    end else if (i_z_r) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q  <= '0;
      row0_q <= 1'b1;
      v_q    <= 1'b0;
      d_q    <= '0;
      up_q   <= '0;
      upv_q  <= 1'b0;
      lx_q   <= 1'b0;
      ly_q   <= 1'b0;
    end else begin
      col_q  <= col_d;
      row0_q <= row0_d;
      v_q    <= v_d;
      d_q    <= d_d;
      up_q   <= up_d;
      upv_q  <= upv_d;
      lx_q   <= lx_d;
      ly_q   <= ly_d;
    end
  end

  // line memory is never reset; read-before-write on the same column
  always_ff @(posedge clk) begin
    if (acc & ~reset) line_q[col_q] <= i_a_d;
  end

  assign o_z_v      = v_q;
  assign o_z_d      = d_q;
  assign o_z_up     = up_q;
  assign o_z_up_v   = upv_q;
  assign o_z_last_x = lx_q;
  assign o_z_last_y = ly_q;

endmodule

// File: tb/tb_cory_vtap2.sv
// tb_cory_vtap2: randomized bench for cory_vtap2 (N=8, W=2).
// Reference: frame/line model with an expected-beat queue.
module tb_cory_vtap2;

  localparam int N = 8;
  localparam int W = 2;
  localparam int D = 1 << W;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_a_v;
  logic [N-1:0] i_a_d;
  logic         i_a_last_x;
  logic         i_a_last_y;
  logic         o_a_r;
  logic         o_z_v;
  logic [N-1:0] o_z_d;
  logic [N-1:0] o_z_up;
  logic         o_z_up_v;
  logic         o_z_last_x;
  logic         o_z_last_y;
  logic         i_z_r;

  always #5 clk = ~clk;

  cory_vtap2 #(.N(N), .W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_a_v      (i_a_v),
    .i_a_d      (i_a_d),
    .i_a_last_x (i_a_last_x),
    .i_a_last_y (i_a_last_y),
    .o_a_r      (o_a_r),
    .o_z_v      (o_z_v),
    .o_z_d      (o_z_d),
    .o_z_up     (o_z_up),
    .o_z_up_v   (o_z_up_v),
    .o_z_last_x (o_z_last_x),
    .o_z_last_y (o_z_last_y),
    .i_z_r      (i_z_r)
  );

  typedef struct packed {
    logic [N-1:0] d;
    logic         lx;
    logic         ly;
  } beat_t;

  typedef struct packed {
    logic [N-1:0] d;
    logic [N-1:0] up;
    logic         upv;
    logic         lx;
    logic         ly;
  } out_t;

  beat_t        src[$];
  out_t         exp_q[$];
  logic [N-1:0] line[D];
  int           mcol;
  bit           mrow0;
  int           checks = 0;
  int           failures = 0;
  int           zphase = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode 0: d=10y+x, 1: base+index, 2: random with stray last_y
  task automatic gen_frame(int w, int h, int mode, int base);
    beat_t b;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        case (mode)
          0:       b.d = N'(10 * y + x);
          1:       b.d = N'(base + y * w + x);
          default: b.d = N'($urandom);
        endcase
        b.lx = (x == w - 1);
        b.ly = (y == h - 1) && b.lx;
        if (mode == 2 && !b.lx && $urandom_range(0, 7) == 0)
          b.ly = 1'b1;
        src.push_back(b);
      end
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    mcol  = 0;
    mrow0 = 1'b1;
  endtask

  // one cycle; zmode 0: ready=1, 1: 1,0,0,1 pattern, 2: random
  task automatic step(int zmode);
    bit    rdy, acc;
    beat_t b;
    out_t  o;
    @(negedge clk);
    case (zmode)
      0:       i_z_r = 1'b1;
      1:       i_z_r = (zphase % 4 == 0) || (zphase % 4 == 3);
      default: i_z_r = ($urandom_range(0, 2) != 0);
    endcase
    zphase++;
    if (src.size() != 0) begin
      b          = src[0];
      i_a_v      = (zmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_a_d      = b.d;
      i_a_last_x = b.lx;
      i_a_last_y = b.ly;
    end else begin
      i_a_v      = 1'b0;
      i_a_d      = N'($urandom);
      i_a_last_x = 1'($urandom);
      i_a_last_y = 1'($urandom);
    end
    #1;
    rdy = (exp_q.size() == 0) || i_z_r;
    chk("a_r", o_a_r, rdy);
    acc = i_a_v && rdy;
    if (acc) begin
      b = src.pop_front();
      o.d   = b.d;
      o.upv = !mrow0;
`ifdef CORY_VTAP2_BORDER_REPLICATE_EN
      o.up  = mrow0 ? b.d : line[mcol];
`else
      o.up  = mrow0 ? '0 : line[mcol];
`endif
      o.lx  = b.lx;
      o.ly  = b.ly;
      line[mcol] = b.d;
      mcol = b.lx ? 0 : (mcol + 1) % D;
      if (b.lx) mrow0 = b.ly;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      exp_q.push_back(o);
    end else if (i_z_r && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    chk("z_v", o_z_v, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      o = exp_q[0];
      chk("z_d", o_z_d, o.d);
      chk("z_up", o_z_up, o.up);
      chk("z_up_v", o_z_up_v, o.upv);
      chk("z_last_x", o_z_last_x, o.lx);
      chk("z_last_y", o_z_last_y, o.ly);
    end
  endtask

  task automatic run(int zmode, int maxc, output int n);
    n = 0;
    while ((src.size() != 0 || exp_q.size() != 0) && n < maxc) begin
      step(zmode);
      n++;
    end
    chk("drain", src.size() + exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    i_a_v = 1'b0;
    i_z_r = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    chk("rst_z_v", o_z_v, 0);
    chk("rst_z_d", o_z_d, 0);
    chk("rst_z_up", o_z_up, 0);
    chk("rst_z_up_v", o_z_up_v, 0);
    chk("rst_last", {o_z_last_x, o_z_last_y}, 0);
    chk("rst_a_r", o_a_r, 1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    i_a_v      = 1'b0;
    i_a_d      = '0;
    i_a_last_x = 1'b0;
    i_a_last_y = 1'b0;
    i_z_r      = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    gen_frame(4, 3, 0, 0);
    run(0, 200, n);
    chk("thruput", n, 13);

    gen_frame(4, 3, 0, 0);
    run(1, 400, n);

    gen_frame(2, 2, 1, 1);
    gen_frame(2, 2, 1, 5);
    run(0, 200, n);

    gen_frame(4, 3, 0, 0);
    for (int i = 0; i < 5; i++) step(0);
    src.delete();
    do_reset();
    gen_frame(4, 3, 1, 100);
    run(0, 200, n);

    // row of 6 with no last_x inside: column wraps at 4
    gen_frame(6, 2, 1, 40);
    run(2, 400, n);

    for (int f = 0; f < 25; f++) begin
      gen_frame($urandom_range(1, 6), $urandom_range(1, 4), 2, 0);
      run(2, 1000, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cory_vtap2.md
# cory_vtap2

Streaming vertical 2-tap window stage that sits directly downstream of `cory_loop2d`. It consumes the raster-ordered beats that `cory_loop2d` emits, along with their `last_x`/`last_y` markers. For every beat it outputs the current sample and the sample at the same column in the previous row, taken from an internal one-line buffer. Downstream vertical filters and edge detectors use these pairs without keeping their own line memory.

## Interface
Parameters:
- `N`, 8, data width.
- `W`, 8, column-pointer width; maximum line length is 2^W beats.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `i_a_v`  in  1  input beat valid; connects to `cory_loop2d` `o_z_v`.
- `i_a_d`  in  N  input sample.
- `i_a_last_x`  in  1  last beat of the row.
- `i_a_last_y`  in  1  last row of the frame; qualifies `i_a_last_x`.
- `o_a_r`  out  1  input ready.
- `o_z_v`  out  1  output valid.
- `o_z_d`  out  N  current sample.
- `o_z_up`  out  N  sample at the same column, previous row.
- `o_z_up_v`  out  1  `o_z_up` holds real previous-row data; 0 on the first row.
- `o_z_last_x`  out  1  registered copy of `i_a_last_x`.
- `o_z_last_y`  out  1  registered copy of `i_a_last_y`.
- `i_z_r`  in  1  output ready.

## Operation
- Accept condition: `acc = i_a_v & o_a_r`, with `o_a_r = ~o_z_v | i_z_r`. This is a single output register with no skid.
- Line buffer: 2^W entries of N bits. It is not reset; its contents are don't-care until written.
- Column pointer `col` is W bits and resets to 0. On `acc`:
  - `col` is set to 0 if `i_a_last_x`; otherwise `col` increments.
  - If no `last_x` arrives, `col` wraps from 2^W-1 to 0 silently. No error flag is raised.
- On `acc`, within the same cycle, the block reads `buf[col]` before writing `i_a_d` into `buf[col]`. The old value goes to `o_z_up`.
- First-row flag `row0`:
  - Set to 1 on reset.
  - Set to 1 on `acc & i_a_last_x & i_a_last_y`, which ends the frame.
  - Cleared on `acc & i_a_last_x & ~i_a_last_y`.
- `i_a_last_y` without `i_a_last_x` is ignored for `row0`. It is still forwarded to `o_z_last_y`.
- Output register load on `acc`:
  - `o_z_d` = `i_a_d`.
  - `o_z_up_v` = `~row0`.
  - `o_z_up` = `buf[col]` when `~row0`; otherwise the border value (see Configuration).
  - `o_z_last_x` and `o_z_last_y` take their input values.
- Output valid update:
  - On `acc`, `o_z_v` is set to 1.
  - On `~acc & i_z_r`, `o_z_v` is cleared to 0.
  - Otherwise `o_z_v` holds.
- Stall: while `o_z_v & ~i_z_r`, all output fields hold stable, `o_a_r` is 0, and `col`, `row0` and the buffer do not change.
- Frame boundary: the first row of every frame reports `o_z_up_v` = 0. Data left in the buffer from the previous frame is never flagged valid.

## Timing
- Latency is 1 cycle: a beat accepted in cycle t appears on `o_z_*` in cycle t+1.
- Throughput is 1 beat/cycle when `i_z_r` is held high.
- A simultaneous output drain and new accept in the same cycle is allowed. `o_z_v` stays 1 and the fields update.
- Reset values:
  - `o_z_v` = 0, `o_z_d` = 0, `o_z_up` = 0, `o_z_up_v` = 0, `o_z_last_x` = 0, `o_z_last_y` = 0.
  - `col` = 0, `row0` = 1.
  - `o_a_r` = 1 in the first cycle after reset.
- Reset mid-frame drops the pending output beat and restarts at column 0 on the first row. The next row after reset reads stale buffer data, which is correct only if the upstream `cory_loop2d` was reset at the same time.
- `o_a_r` combinationally depends on `i_z_r` and `o_z_v` only, never on `i_a_v`.

## Configuration
- Macro `CORY_VTAP2_BORDER_REPLICATE_EN`.
- Defined: on the first row `o_z_up` = `i_a_d`, so the top border is replicated.
- Undefined: on the first row `o_z_up` = 0, so the top border is zero-padded.
- `o_z_up_v` is 0 on the first row in both builds. The buffer write path is the same in both builds.

## Test plan
- Frame of 4x3 with values d = 10*y + x, `i_z_r` = 1. Required response:
  - Row 0 gives `up_v` = 0 and `up` = 0 (undefined macro).
  - Rows 1-2 give `up` = d-10 and `up_v` = 1.
  - `last_x` appears on x = 3; `last_y` appears on the beat at (3,2).
  - 12 beats come out over 12 consecutive cycles.
- Same frame with the macro defined: row 0 gives `up` = `d`. All other rows are unchanged.
- Backpressure pattern on `i_z_r` (1,0,0,1 repeating) with `i_a_v` held high:
  - `o_a_r` = 0 whenever `o_z_v` & ~`i_z_r`.
  - Output fields hold while stalled.
  - The sequence matches the first test with no drops and no duplicates.
- Two back-to-back frames of 2x2 with values 1..4 then 5..8: the second frame's row 0 gives `up_v` = 0 and `up` does not equal 3 or 4 (zero-pad build); its row 1 gives `up` = 5, 6.
- Reset asserted after 5 beats of a 4x3 frame: the next cycle has `o_z_v` = 0; the following frame starts with `up_v` = 0 at column 0.
- W = 2 with a row of 6 beats and no `last_x`: `col` wraps; beat 5 writes entry 1; the next row's column-1 beat reads the beat-5 value.
